sb_bus_arbiter: RTL and testbench
=================================

SB_BUS_ARBITER -- requirements
Module: sb_bus_arbiter

Interface
REQ-001 Parameter N_SLAVES, default 8, number of peripheral slots; legal range 1..256.
REQ-002 clk_i  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 m0_req_i, m1_req_i  input  1 each  master request; m0 is the core LSU, m1 is the loader/debug port.
REQ-005 m0_we_i, m1_we_i  input  1 each  1 = write, 0 = read.
REQ-006 m0_addr_i, m1_addr_i  input  32 each  byte address; [31:24] selects the slot, [23:0] is the slave-local offset.
REQ-007 m0_wdata_i, m1_wdata_i  input  32 each  write data.
REQ-008 m0_rdata_o, m1_rdata_o  output  32 each  read data; valid only while the matching ready is high, 0 otherwise.
REQ-009 m0_ready_o, m1_ready_o  output  1 each  one-cycle transaction-complete pulse.
REQ-010 s_req_o  output  N_SLAVES  one-hot slave request.
REQ-011 s_we_o  output  1  write enable to all slaves.
REQ-012 s_addr_o  output  32  {8'h00, granted addr[23:0]}.
REQ-013 s_wdata_o  output  32  granted write data.
REQ-014 s_rdata_i  input  32*N_SLAVES  flattened slave read data; slot k occupies bits [32k+31:32k]; each slave registers read data, so it is valid one cycle after its request.
REQ-015 err_o  output  1  decode-error pulse, coincident with ready.

Function
REQ-016 FSM states: IDLE and RD_WAIT; reset state is IDLE.
REQ-017 IDLE, no request pending: all s_* outputs 0, both ready outputs 0.
REQ-018 IDLE, exactly one master requesting: that master is granted combinationally in the same cycle.
REQ-019 IDLE, both masters requesting: round-robin; the master not recorded in last_gnt wins; the loser is stalled (ready low) until a later grant.
REQ-020 last_gnt is updated on every grant.
REQ-021 Granted write: s_req_o[sel], s_we_o, s_addr_o and s_wdata_o are driven in the grant cycle; the master's ready pulses in that same cycle; FSM stays IDLE.
REQ-022 Granted read: the slave request is driven in the grant cycle; the FSM enters RD_WAIT; the read target and owner are registered.
REQ-023 RD_WAIT: s_req_o = 0; owner ready = 1; owner rdata = s_rdata_i slice of the registered slot; next state IDLE.
REQ-024 RD_WAIT: new requests from either master are not granted in that cycle.
REQ-025 Read latency is 2 cycles (request to ready); write latency is 1 cycle; the next grant is possible in the cycle after RD_WAIT.
REQ-026 Masters hold req/we/addr/wdata stable until ready; a request dropped before ready is not tracked.
REQ-027 sel = addr[31:24]; sel >= N_SLAVES is out-of-range: no s_req_o bit asserted; the transaction still completes with normal latency.
REQ-028 A given master never receives two ready pulses for one transaction.
REQ-029 m0_ready_o and m1_ready_o are never high in the same cycle.

Reset
REQ-030 While rst is high: FSM = IDLE, last_gnt = m1 (so m0 wins the first conflict), registered owner/slot = 0.
REQ-031 While rst is high: all outputs 0, including s_req_o, ready and err_o.
REQ-032 Reset asserted in RD_WAIT aborts the read: no ready pulse is issued afterwards.

Configuration
REQ-033 The `SB_ADDR_ERR_EN` macro enables decode-error reporting.
REQ-034 With `SB_ADDR_ERR_EN` defined, on an out-of-range transaction: err_o pulses with ready; reads return 32'hDEADBEEF; writes are dropped.
REQ-035 Without `SB_ADDR_ERR_EN`: err_o is tied 0; out-of-range reads return 32'h0; writes are dropped silently.

Verification
REQ-036 m0 write to addr 32'h0100_0004, data 1 -> s_req_o = 8'b0000_0010, s_addr_o = 32'h4 and m0_ready_o all in the same cycle.
REQ-037 m0 read of 32'h0100_0000 with slot-1 rdata = 32'h0000_A5A5 one cycle later -> m0_ready_o in cycle 2 with m0_rdata_o = 32'h0000_A5A5.
REQ-038 m0 and m1 both continuously requesting writes after reset -> grant order m0, m1, m0, m1; no cycle with both ready outputs high.
REQ-039 m1 read in RD_WAIT while m0 raises a request -> m0 waits for the RD_WAIT cycle and is granted in the following cycle.
REQ-040 rst asserted during RD_WAIT -> no ready pulse follows and all outputs are 0 in the cycle after reset.
REQ-041 Read of 32'h0900_0000 with N_SLAVES = 8 -> with the macro: rdata 32'hDEADBEEF and err_o = 1; without the macro: rdata 0 and err_o = 0; no s_req_o bit asserted in either case.

Source files
------------

// File: rtl/sb_bus_arbiter.sv
// sb_bus_arbiter: two-master / N-slot system bus arbiter.
// m0 (core LSU) and m1 (loader/debug) share one slave bus. Round-robin on
// conflict, writes complete in the grant cycle, reads complete one cycle
// later in RD_WAIT when the registered slave data arrives.
// Optional build macro SB_ADDR_ERR_EN: out-of-range accesses raise err_o
// and reads return 32'hDEADBEEF instead of 0.
module sb_bus_arbiter #(
  parameter int N_SLAVES = 8
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     m0_req_i,
  input  logic                     m0_we_i,
  input  logic [31:0]              m0_addr_i,
  input  logic [31:0]              m0_wdata_i,
  output logic [31:0]              m0_rdata_o,
  output logic                     m0_ready_o,
  input  logic                     m1_req_i,
  input  logic                     m1_we_i,
  input  logic [31:0]              m1_addr_i,
  input  logic [31:0]              m1_wdata_i,
  output logic [31:0]              m1_rdata_o,
  output logic                     m1_ready_o,
  output logic [N_SLAVES-1:0]      s_req_o,
  output logic                     s_we_o,
  output logic [31:0]              s_addr_o,
  output logic [31:0]              s_wdata_o,
  input  logic [32*N_SLAVES-1:0]   s_rdata_i,
  output logic                     err_o
);

`ifdef SB_ADDR_ERR_EN
  localparam logic        ERR_EN    = 1'b1;
  localparam logic [31:0] OOR_RDATA = 32'hDEAD_BEEF;
`else
  localparam logic        ERR_EN    = 1'b0;
  localparam logic [31:0] OOR_RDATA = 32'h0;
`endif

  // 9-bit slot count so N_SLAVES = 256 compares correctly against 8-bit sel
  localparam logic [8:0] N_SLV = 9'(N_SLAVES);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;   // 1 = m1 had the last grant
  logic        rd_owner_q, rd_owner_d;   // 1 = m1 owns the pending read
  logic [7:0]  rd_slot_q, rd_slot_d;

  logic        gnt_m0, gnt_m1;
  logic        g_we;
  logic [31:0] g_addr, g_wdata;
  logic [7:0]  g_sel;
  logic        g_in_range, rd_in_range;
  logic [31:0] rd_mux, rd_data;

  // Read-data mux over the registered slot; stays 0 when the slot is unmapped
  always_comb begin
    rd_mux = 32'h0;
    for (int k = 0; k < N_SLAVES; k++)
      if (rd_slot_q == 8'(k)) rd_mux = s_rdata_i[32*k +: 32];
  end

  // Arbitration, slave-side drive and master completion
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    rd_owner_d = rd_owner_q;
    rd_slot_d  = rd_slot_q;
    s_req_o    = '0;
    s_we_o     = 1'b0;
    s_addr_o   = 32'h0;
    s_wdata_o  = 32'h0;
    m0_ready_o = 1'b0;
    m1_ready_o = 1'b0;
    m0_rdata_o = 32'h0;
    m1_rdata_o = 32'h0;
    err_o      = 1'b0;
    rd_data    = 32'h0;

    // m1 wins when alone, or on conflict when m0 had the last grant
    gnt_m1 = m1_req_i & (~m0_req_i | ~last_gnt_q);
    gnt_m0 = m0_req_i & ~gnt_m1;

    g_we        = gnt_m1 ? m1_we_i    : m0_we_i;
    g_addr      = gnt_m1 ? m1_addr_i  : m0_addr_i;
    g_wdata     = gnt_m1 ? m1_wdata_i : m0_wdata_i;
    g_sel       = g_addr[31:24];
    g_in_range  = {1'b0, g_sel} < N_SLV;
    rd_in_range = {1'b0, rd_slot_q} < N_SLV;

    case (state_q)
      IDLE: begin
        if (gnt_m0 | gnt_m1) begin
          last_gnt_d = gnt_m1;
          s_we_o     = g_we;
          s_addr_o   = {8'h00, g_addr[23:0]};
          s_wdata_o  = g_wdata;
          // Unmapped sel matches no k, so out-of-range requests go nowhere
          for (int k = 0; k < N_SLAVES; k++)
            s_req_o[k] = (g_sel == 8'(k));
          if (g_we) begin
            m0_ready_o = gnt_m0;
            m1_ready_o = gnt_m1;
            err_o      = ERR_EN & ~g_in_range;
          end else begin
            state_d    = RD_WAIT;
            rd_owner_d = gnt_m1;
            rd_slot_d  = g_sel;
          end
        end
      end
      RD_WAIT: begin
        state_d = IDLE;
        rd_data = rd_in_range ? rd_mux : OOR_RDATA;
        err_o   = ERR_EN & ~rd_in_range;
        if (rd_owner_q) begin
          m1_ready_o = 1'b1;
          m1_rdata_o = rd_data;
        end else begin
          m0_ready_o = 1'b1;
          m0_rdata_o = rd_data;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset silences every output, including any in-flight read completion
    if (rst) begin
      s_req_o    = '0;
      s_we_o     = 1'b0;
      s_addr_o   = 32'h0;
      s_wdata_o  = 32'h0;
      m0_ready_o = 1'b0;
      m1_ready_o = 1'b0;
      m0_rdata_o = 32'h0;
      m1_rdata_o = 32'h0;
      err_o      = 1'b0;
    end
  end

  // State, round-robin pointer and pending-read bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      rd_owner_q <= 1'b0;
      rd_slot_q  <= 8'h0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      rd_owner_q <= rd_owner_d;
      rd_slot_q  <= rd_slot_d;
    end
  end

endmodule

// File: tb/tb_sb_bus_arbiter.sv
// Directed bench for sb_bus_arbiter (N_SLAVES = 8). Inputs change 1 ns after
// the rising edge; outputs are checked 2 ns after the edge.
module tb_sb_bus_arbiter;
  localparam int NS = 8;

  logic              clk_i = 1'b0;
  logic              rst;
  logic              m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0]       m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [31:0]       m0_rdata_o, m1_rdata_o;
  logic              m0_ready_o, m1_ready_o;
  logic [NS-1:0]     s_req_o;
  logic              s_we_o, err_o;
  logic [31:0]       s_addr_o, s_wdata_o;
  logic [32*NS-1:0]  s_rdata_i;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SB_ADDR_ERR_EN
  localparam logic [31:0] EXP_OOR = 32'hDEAD_BEEF;
  localparam logic        EXP_ERR = 1'b1;
`else
  localparam logic [31:0] EXP_OOR = 32'h0;
  localparam logic        EXP_ERR = 1'b0;
`endif

  sb_bus_arbiter #(.N_SLAVES(NS)) dut (
    .clk_i(clk_i), .rst(rst),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o), .m0_ready_o(m0_ready_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o), .m1_ready_o(m1_ready_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs may be changed right after, checks after settle
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_masters();
    m0_req_i = 0; m0_we_i = 0; m0_addr_i = 0; m0_wdata_i = 0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_i = 0; m1_wdata_i = 0;
  endtask

  initial begin
    rst = 1; s_rdata_i = '0;
    idle_masters();
    // A request during reset must see no response at all
    m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h0100_0004; m0_wdata_i = 32'h1;
    step(); settle();
    chk("rst_sreq",  32'(s_req_o), 32'h0);
    chk("rst_rdy0",  32'(m0_ready_o), 32'h0);
    chk("rst_addr",  s_addr_o, 32'h0);
    chk("rst_err",   32'(err_o), 32'h0);

    step(); rst = 0; idle_masters(); settle();
    chk("idle_sreq", 32'(s_req_o), 32'h0);
    chk("idle_rdy",  32'({m0_ready_o, m1_ready_o}), 32'h0);

    // Write to slot 1, offset 4: complete in the grant cycle
    step(); m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h0100_0004; m0_wdata_i = 32'h1; settle();
    chk("wr_sreq",  32'(s_req_o), 32'h2);
    chk("wr_addr",  s_addr_o, 32'h4);
    chk("wr_wdata", s_wdata_o, 32'h1);
    chk("wr_we",    32'(s_we_o), 32'h1);
    chk("wr_rdy",   32'({m0_ready_o, m1_ready_o}), 32'h2);

    // Read slot 1: request now, data/ready next cycle
    step(); m0_we_i = 0; m0_addr_i = 32'h0100_0000; m0_wdata_i = 0; settle();
    chk("rd_sreq",  32'(s_req_o), 32'h2);
    chk("rd_rdy_c1", 32'(m0_ready_o), 32'h0);
    step(); s_rdata_i[32*1 +: 32] = 32'h0000_A5A5; settle();
    chk("rd_rdy_c2", 32'(m0_ready_o), 32'h1);
    chk("rd_data",  m0_rdata_o, 32'h0000_A5A5);
    chk("rd_sreq2", 32'(s_req_o), 32'h0);
    chk("rd_m1data", m1_rdata_o, 32'h0);
    step(); idle_masters(); settle();
    chk("rd_after", 32'(m0_ready_o), 32'h0);

    // Fresh reset so m0 wins the first conflict
    step(); rst = 1;
    step(); rst = 0;
    m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h0000_0010; m0_wdata_i = 32'hAAAA;
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h0200_0020; m1_wdata_i = 32'hBBBB;
    settle();
    chk("rr1_rdy",  32'({m0_ready_o, m1_ready_o}), 32'h2);
    chk("rr1_sreq", 32'(s_req_o), 32'h1);
    step(); settle();
    chk("rr2_rdy",  32'({m0_ready_o, m1_ready_o}), 32'h1);
    chk("rr2_sreq", 32'(s_req_o), 32'h4);
    chk("rr2_wd",   s_wdata_o, 32'hBBBB);
    step(); settle();
    chk("rr3_rdy",  32'({m0_ready_o, m1_ready_o}), 32'h2);
    step(); settle();
    chk("rr4_rdy",  32'({m0_ready_o, m1_ready_o}), 32'h1);

    // m1 reads slot 3; m0 arrives during RD_WAIT and must wait one cycle
    step(); idle_masters(); m1_req_i = 1; m1_addr_i = 32'h0300_0000; settle();
    chk("w39_sreq", 32'(s_req_o), 32'h8);
    chk("w39_rdy",  32'({m0_ready_o, m1_ready_o}), 32'h0);
    step(); s_rdata_i[32*3 +: 32] = 32'h1234_5678;
    m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h0000_0000; m0_wdata_i = 32'h55; settle();
    chk("w39_rdwait_rdy", 32'({m0_ready_o, m1_ready_o}), 32'h1);
    chk("w39_m1data", m1_rdata_o, 32'h1234_5678);
    chk("w39_rdwait_sreq", 32'(s_req_o), 32'h0);
    step(); m1_req_i = 0; m1_addr_i = 0; settle();
    chk("w39_m0_rdy", 32'({m0_ready_o, m1_ready_o}), 32'h2);
    chk("w39_m0_sreq", 32'(s_req_o), 32'h1);

    // Out-of-range read: no slave request, normal latency
    step(); idle_masters(); m0_req_i = 1; m0_addr_i = 32'h0900_0000; settle();
    chk("oor_rd_sreq", 32'(s_req_o), 32'h0);
    chk("oor_rd_rdy1", 32'(m0_ready_o), 32'h0);
    step(); settle();
    chk("oor_rd_rdy2", 32'(m0_ready_o), 32'h1);
    chk("oor_rd_data", m0_rdata_o, EXP_OOR);
    chk("oor_rd_err",  32'(err_o), 32'(EXP_ERR));

    // Out-of-range write: dropped, completes in one cycle
    step(); m0_we_i = 1; m0_addr_i = 32'h0800_0000; m0_wdata_i = 32'h77; settle();
    chk("oor_wr_sreq", 32'(s_req_o), 32'h0);
    chk("oor_wr_rdy",  32'(m0_ready_o), 32'h1);
    chk("oor_wr_err",  32'(err_o), 32'(EXP_ERR));

    // Reset during RD_WAIT aborts the read
    step(); m0_we_i = 0; m0_addr_i = 32'h0100_0000; m0_wdata_i = 0; settle();
    chk("abort_sreq", 32'(s_req_o), 32'h2);
    step(); rst = 1; settle();
    chk("abort_rst_rdy", 32'({m0_ready_o, m1_ready_o}), 32'h0);
    step(); rst = 0; idle_masters(); settle();
    chk("abort_post_rdy",  32'({m0_ready_o, m1_ready_o}), 32'h0);
    chk("abort_post_sreq", 32'(s_req_o), 32'h0);
    chk("abort_post_data", m0_rdata_o, 32'h0);
    chk("abort_post_err",  32'(err_o), 32'h0);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Both ready outputs must never be high together
  always @(negedge clk_i) begin
    if (!rst && m0_ready_o && m1_ready_o) begin
      n_fail++;
      $error("FAIL both_ready: observed 11 expected at most one ready");
    end
  end

  // Safety bound on total run time
  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
